conbus_arb: RTL and testbench
=============================

CONBUS_ARB -- requirements
Module: conbus_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the number of cycles a granted strobe may wait for ack before abort (1..255).
REQ-002 SHALL have parameter ADR_W, default 32, giving the address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports mN_adr_i (N=0,1), input, ADR_W bits: master address; m0 = LM32 instruction bus, m1 = LM32 data bus.
REQ-006 SHALL have ports mN_dat_i, input, 32 bits, and mN_dat_o, output, 32 bits: master write data and read data.
REQ-007 SHALL have ports mN_sel_i, input, 4 bits, and mN_we_i, mN_cyc_i, mN_stb_i, input, 1 bit each: master byte select and control.
REQ-008 SHALL have ports mN_ack_o and mN_err_o, output, 1 bit each: master acknowledge and timeout error.
REQ-009 SHALL have ports s_adr_o (ADR_W), s_dat_o (32), s_sel_o (4), s_we_o, s_cyc_o, s_stb_o (1 each), all outputs: the shared slave-side bus.
REQ-010 SHALL have ports s_dat_i, input, 32 bits, and s_ack_i, input, 1 bit: slave read data and acknowledge.
REQ-011 SHALL have port gnt_o, output, 2 bits: one-hot current grant, 2'b00 when idle.
REQ-012 SHALL have port tmo_cnt_o, output, 8 bits: saturating count of timeout aborts.

Function
REQ-013 SHALL implement FSM states IDLE, G0 and G1, with the state registered.
REQ-014 IDLE: m0_cyc_i only -> G0; m1_cyc_i only -> G1; both -> the master not served last; neither -> stay in IDLE.
REQ-015 A grant SHALL be held while the granted mN_cyc_i=1; on its deassertion -> IDLE the next cycle, with no back-to-back handover.
REQ-016 Request-to-grant latency SHALL be 1 cycle: cyc sampled in cycle N gives s_cyc_o=1 in cycle N+1.
REQ-017 s_* outputs SHALL be a combinational mux of the granted master's inputs selected by registered state; in IDLE, s_cyc_o=s_stb_o=s_we_o=0 and s_adr_o/s_dat_o/s_sel_o=0.
REQ-018 s_ack_i SHALL be routed only to the granted mN_ack_o; the non-granted ack SHALL be 0.
REQ-019 s_dat_i SHALL drive both mN_dat_o.
REQ-020 A last-served flag SHALL update on each entry into G0/G1; its reset value selects m0 as first winner.
REQ-021 Watchdog: an 8-bit counter SHALL increment each cycle in which the granted strobe=1 and s_ack_i=0, and clear on ack, on strobe low, or in IDLE.
REQ-022 When the watchdog counter reaches TIMEOUT-1 with no ack, the granted mN_err_o=1 for exactly that cycle.
REQ-023 In that same cycle s_stb_o SHALL be forced to 0, the counter SHALL clear, and tmo_cnt_o SHALL increment, saturating at 255.
REQ-024 If ack and timeout coincide, ack SHALL win: no err and no count.
REQ-025 mN_err_o and mN_ack_o SHALL never be 1 in the same cycle.
REQ-026 A master dropping cyc mid-wait SHALL abandon its transfer silently, with no err.

Reset
REQ-027 On rst=0, asynchronously: state=IDLE, last-served=m1, watchdog counter=0, tmo_cnt_o=0.
REQ-028 During reset all outputs SHALL be 0: gnt_o=00, s_cyc_o=0, mN_ack_o=0, mN_err_o=0.
REQ-029 Reset asserted mid-transfer SHALL drop s_cyc_o immediately; after reset the arbiter restarts in IDLE.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=2'd0, G0=2'd1, G1=2'd2) and the default TIMEOUT constant.
REQ-031 The watchdog SHALL be one sub-module, conbus_wdt (counter, compare and saturating abort count); the FSM and mux SHALL stay in conbus_arb.

Verification
REQ-032 m0 single read, slave acks 2 cycles after s_stb_o -> gnt_o=01 one cycle after m0_cyc_i, m0_ack_o=1 for 1 cycle, m0_dat_o=s_dat_i=0xDEADBEEF, m1_ack_o=0.
REQ-033 m0_cyc_i and m1_cyc_i both rise from reset in the same cycle -> gnt_o=01 first; m0 drops cyc -> IDLE one cycle, then gnt_o=10.
REQ-034 m1 holds cyc for 4 back-to-back acked writes while m0 requests -> grant stays on m1 for all 4, and m0 is granted only after m1_cyc_i=0.
REQ-035 TIMEOUT=8, slave never acks -> m1_err_o=1 in the 8th stalled cycle, s_stb_o=0 that cycle, tmo_cnt_o=1.
REQ-036 TIMEOUT=8, s_ack_i arrives in the 8th stalled cycle -> ack delivered, no err, tmo_cnt_o unchanged.
REQ-037 rst=0 pulse while G1 with stb pending -> s_cyc_o=0 and gnt_o=00 without waiting for a clock edge; next arbitration favours m0.

Source files
------------

// File: rtl/conbus_arb_pkg.sv
// Shared definitions for the two-master conbus arbiter: state encoding,
// master identifiers, bus widths and the default watchdog limit.
package conbus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } arb_state_e;

    typedef enum logic {
        MST_0 = 1'b0,
        MST_1 = 1'b1
    } master_e;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int DAT_W           = 32;
    localparam int SEL_W           = 4;
    localparam int CNT_W           = 8;

    // Round-robin pick from IDLE: a lone requester wins, a tie goes to
    // whichever master was not served last.
    function automatic arb_state_e pick_grant(input logic    c0,
                                              input logic    c1,
                                              input master_e last);
        arb_state_e res;
        res = ST_IDLE;
        if (c0 && (!c1 || last == MST_1)) begin
            res = ST_G0;
        end else if (c1) begin
            res = ST_G1;
        end
        return res;
    endfunction

endpackage

// File: rtl/conbus_wdt.sv
// Ack watchdog: counts stalled strobe cycles, aborts at TIMEOUT-1, and keeps
// a saturating count of aborts. Abort output is combinational from the count.
module conbus_wdt
    import conbus_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active_i,
    input  logic             stb_i,
    input  logic             ack_i,
    output logic             tmo_o,
    output logic [CNT_W-1:0] tmo_cnt_o
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] abort_q, abort_d;
    logic             stall;

    assign stall = active_i && stb_i && !ack_i;

    // Ack in the limit cycle clears stall, so ack always beats the abort.
    always_comb begin
        tmo_o   = stall && (cnt_q == LIMIT);
        cnt_d   = cnt_q;
        abort_d = abort_q;
        if (!stall || tmo_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (tmo_o && abort_q != CNT_MAX) begin
            abort_d = abort_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            abort_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    assign tmo_cnt_o = abort_q;

endmodule

// File: rtl/conbus_arb.sv
// Two-master (LM32 I/D) to one-slave Wishbone-style arbiter with round-robin
// grant, 1-cycle grant latency, and a strobe watchdog that aborts with err.
module conbus_arb
    import conbus_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int ADR_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic [DAT_W-1:0] m0_dat_o,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic             m0_we_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic [DAT_W-1:0] m1_dat_o,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic             m1_we_i,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic             s_we_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    output logic [1:0]       gnt_o,
    output logic [CNT_W-1:0] tmo_cnt_o
);

    arb_state_e state_q;
    master_e    last_q;
    logic       gnt0, gnt1;
    logic       g_stb;
    logic       tmo;

    // A grant is held until its owner drops cyc; IDLE always sits between
    // two grants so the slave sees a clean cycle boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            last_q  <= MST_1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= pick_grant(m0_cyc_i, m1_cyc_i, last_q);
                    if (pick_grant(m0_cyc_i, m1_cyc_i, last_q) == ST_G0) begin
                        last_q <= MST_0;
                    end else if (pick_grant(m0_cyc_i, m1_cyc_i, last_q) == ST_G1) begin
                        last_q <= MST_1;
                    end
                end
                ST_G0: begin
                    if (!m0_cyc_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_G1: begin
                    if (!m1_cyc_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt0  = (state_q == ST_G0);
    assign gnt1  = (state_q == ST_G1);
    assign gnt_o = {gnt1, gnt0};

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        g_stb   = 1'b0;
        if (gnt0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            g_stb   = m0_stb_i && m0_cyc_i;
        end else if (gnt1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            g_stb   = m1_stb_i && m1_cyc_i;
        end
    end

    // Strobe is qualified by cyc so a master that walks away mid-wait just
    // clears the watchdog instead of tripping it.
    conbus_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk       (clk),
        .rst       (rst),
        .active_i  (gnt0 || gnt1),
        .stb_i     (g_stb),
        .ack_i     (s_ack_i),
        .tmo_o     (tmo),
        .tmo_cnt_o (tmo_cnt_o)
    );

    assign s_stb_o  = g_stb && !tmo;
    assign m0_ack_o = gnt0 && s_ack_i;
    assign m1_ack_o = gnt1 && s_ack_i;
    assign m0_err_o = gnt0 && tmo;
    assign m1_err_o = gnt1 && tmo;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_conbus_arb.sv
// Directed bench for conbus_arb: stimulus pushes expected ack/err responses,
// a negedge monitor pops and compares them; grant/strobe timing checked inline.
module tb_conbus_arb;
    import conbus_arb_pkg::*;

    localparam int ADR_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [ADR_W-1:0] m0_adr_i, m1_adr_i;
    logic [31:0]      m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
    logic [3:0]       m0_sel_i, m1_sel_i;
    logic             m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic             m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic [ADR_W-1:0] s_adr_o;
    logic [31:0]      s_dat_o, s_dat_i;
    logic [3:0]       s_sel_o;
    logic             s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic [1:0]       gnt_o;
    logic [7:0]       tmo_cnt_o;

    typedef struct {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] dat;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    conbus_arb #(.TIMEOUT(8), .ADR_W(ADR_W)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o), .tmo_cnt_o(tmo_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ack, input logic [1:0] err, input logic [31:0] dat);
        ev_t e;
        e.ack = ack;
        e.err = err;
        e.dat = dat;
        exp_q.push_back(e);
    endtask

    // Response monitor
    always @(negedge clk) begin
        ev_t e;
        if (rst && (m0_ack_o || m1_ack_o || m0_err_o || m1_err_o)) begin
            chk("ack_err_excl", 32'((m0_ack_o & m0_err_o) | (m1_ack_o & m1_err_o)), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: ack=%b err=%b at %0t",
                         {m1_ack_o, m0_ack_o}, {m1_err_o, m0_err_o}, $time);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_ack", 32'({m1_ack_o, m0_ack_o}), 32'(e.ack));
                chk("rsp_err", 32'({m1_err_o, m0_err_o}), 32'(e.err));
                if (e.ack != 2'b00) begin
                    chk("rsp_dat", m0_ack_o ? m0_dat_o : m1_dat_o, e.dat);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b0;
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        s_dat_i = '0; s_ack_i = 1'b0;

        // Reset state
        #2;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        chk("rst_acks", 32'({m1_ack_o, m0_ack_o}), 32'd0);
        chk("rst_errs", 32'({m1_err_o, m0_err_o}), 32'd0);
        chk("rst_tmo_cnt", 32'(tmo_cnt_o), 32'd0);
        tick(); tick();
        rst = 1'b1;

        // m0 single read, slave acks 2 cycles after strobe
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0100; m0_sel_i = 4'hF;
        #1 chk("a_gnt_pre", 32'(gnt_o), 32'd0);
        tick();
        chk("a_gnt", 32'(gnt_o), 32'b01);
        chk("a_s_cyc", 32'(s_cyc_o), 32'd1);
        chk("a_s_stb", 32'(s_stb_o), 32'd1);
        chk("a_s_adr", s_adr_o, 32'h0000_0100);
        tick();
        tick();
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        push(2'b01, 2'b00, 32'hDEAD_BEEF);
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        chk("a_idle", 32'(gnt_o), 32'd0);

        // Simultaneous requests straight out of reset
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        m0_cyc_i = 1; m1_cyc_i = 1;
        tick();
        chk("b_gnt_m0", 32'(gnt_o), 32'b01);
        m0_cyc_i = 0;
        tick();
        chk("b_idle_gap", 32'(gnt_o), 32'd0);
        tick();
        chk("b_gnt_m1", 32'(gnt_o), 32'b10);
        m1_cyc_i = 0;
        tick();
        chk("b_idle", 32'(gnt_o), 32'd0);

        // m1 keeps cyc across 4 acked writes while m0 waits
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'h3;
        tick();
        chk("c_gnt_m1", 32'(gnt_o), 32'b10);
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int i = 0; i < 4; i++) begin
            m1_dat_i = 32'hA000_0000 + 32'(i);
            s_dat_i  = 32'h0000_1000 + 32'(i);
            s_ack_i  = 1;
            push(2'b10, 2'b00, 32'h0000_1000 + 32'(i));
            #1;
            chk("c_hold_gnt", 32'(gnt_o), 32'b10);
            chk("c_s_dat", s_dat_o, 32'hA000_0000 + 32'(i));
            chk("c_s_we", 32'(s_we_o), 32'd1);
            tick();
        end
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        #1 chk("c_still_m1", 32'(gnt_o), 32'b10);
        tick();
        chk("c_idle", 32'(gnt_o), 32'd0);
        tick();
        chk("c_gnt_m0", 32'(gnt_o), 32'b01);
        s_ack_i = 1; s_dat_i = 32'hCAFE_0000;
        push(2'b01, 2'b00, 32'hCAFE_0000);
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        tick();
        chk("c_idle2", 32'(gnt_o), 32'd0);

        // m1 stalls with no ack: abort in the 8th stalled cycle
        m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        chk("d_gnt_m1", 32'(gnt_o), 32'b10);
        for (int k = 1; k < 8; k++) begin
            #1;
            chk("d_stall_stb", 32'(s_stb_o), 32'd1);
            chk("d_stall_err", 32'(m1_err_o), 32'd0);
            tick();
        end
        push(2'b00, 2'b10, 32'd0);
        #1;
        chk("d_tmo_err", 32'(m1_err_o), 32'd1);
        chk("d_tmo_stb", 32'(s_stb_o), 32'd0);
        chk("d_tmo_cnt_pre", 32'(tmo_cnt_o), 32'd0);
        tick();
        chk("d_tmo_cnt", 32'(tmo_cnt_o), 32'd1);
        chk("d_err_clr", 32'(m1_err_o), 32'd0);
        chk("d_stb_back", 32'(s_stb_o), 32'd1);
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        tick();
        chk("d_idle", 32'(gnt_o), 32'd0);

        // Ack arrives in the 8th stalled cycle: ack wins
        m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        chk("e_gnt_m1", 32'(gnt_o), 32'b10);
        for (int k = 1; k < 8; k++) tick();
        s_ack_i = 1; s_dat_i = 32'h5555_AAAA;
        push(2'b10, 2'b00, 32'h5555_AAAA);
        #1;
        chk("e_no_err", 32'(m1_err_o), 32'd0);
        chk("e_stb_kept", 32'(s_stb_o), 32'd1);
        tick();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        #1 chk("e_tmo_cnt", 32'(tmo_cnt_o), 32'd1);
        tick();
        tick();

        // m0 abandons a stalled transfer: silent, no abort counted
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        chk("f_gnt_m0", 32'(gnt_o), 32'b01);
        tick(); tick();
        m0_cyc_i = 0; m0_stb_i = 0;
        for (int k = 0; k < 10; k++) tick();
        chk("f_tmo_cnt", 32'(tmo_cnt_o), 32'd1);
        chk("f_idle", 32'(gnt_o), 32'd0);

        // Async reset mid-transfer while m1 granted with strobe pending
        m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        chk("g_gnt_m1", 32'(gnt_o), 32'b10);
        #2 rst = 1'b0;
        #1;
        chk("g_rst_s_cyc", 32'(s_cyc_o), 32'd0);
        chk("g_rst_gnt", 32'(gnt_o), 32'd0);
        chk("g_rst_tmo_cnt", 32'(tmo_cnt_o), 32'd0);
        tick();
        rst = 1'b1;
        m0_cyc_i = 1;
        tick();
        chk("g_gnt_m0_first", 32'(gnt_o), 32'b01);
        m0_cyc_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick(); tick();

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
